// File: rtl/maple_frame_decoder.sv
// rtl/maple_frame_decoder.sv - Maple bus start/end pattern and data byte decoder
// Three independent decoders driven by pre-synchronized SDCKA/SDCKB levels and edge strobes.
module maple_frame_decoder #(
   parameter int unsigned START_FRAME_PULSES = 4,
   parameter int unsigned START_CRC_PULSES   = 6,
   parameter int unsigned START_OCC_PULSES   = 8,
   parameter int unsigned START_RESET_PULSES = 14,
   parameter int unsigned END_PULSES         = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       sdcka_data,
   input  logic       sdckb_data,
   input  logic       sdcka_posedge,
   input  logic       sdcka_negedge,
   input  logic       sdckb_posedge,
   input  logic       sdckb_negedge,
   output logic       start_frame,
   output logic       start_with_crc,
   output logic       start_occupancy,
   output logic       start_reset,
   output logic       start_frame_error,
   output logic       end_frame,
   output logic       end_frame_error,
   output logic [7:0] data,
   output logic       write
);

   typedef enum logic {S_IDLE, S_COUNT} pat_state_t;

   localparam logic [3:0] CNT_FRAME = 4'(START_FRAME_PULSES);
   localparam logic [3:0] CNT_CRC   = 4'(START_CRC_PULSES);
   localparam logic [3:0] CNT_OCC   = 4'(START_OCC_PULSES);
   localparam logic [3:0] CNT_RESET = 4'(START_RESET_PULSES);
   localparam logic [3:0] CNT_END   = 4'(END_PULSES);

   pat_state_t st_state_q, st_state_d;
   logic [3:0] st_cnt_q, st_cnt_d;
   pat_state_t en_state_q, en_state_d;
   logic [3:0] en_cnt_q, en_cnt_d;

   logic sf_q, sf_d, crc_q, crc_d, occ_q, occ_d, rst_q, rst_d, sferr_q, sferr_d;
   logic ef_q, ef_d, eferr_q, eferr_d;

   logic       phase_q, phase_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [6:0] shift_q, shift_d;
   logic [7:0] data_q, data_d;
   logic       write_q, write_d;
   logic       take_bit;
   logic       bit_in;

   // Start pattern: A falls with B high, count B falls, classify on A rise.
   always_comb begin
      st_state_d = st_state_q;
      st_cnt_d   = st_cnt_q;
      sf_d       = 1'b0;
      crc_d      = 1'b0;
      occ_d      = 1'b0;
      rst_d      = 1'b0;
      sferr_d    = 1'b0;
      case (st_state_q)
         S_IDLE: begin
            if (sdcka_negedge && sdckb_data) begin
               st_state_d = S_COUNT;
               st_cnt_d   = 4'd0;
            end
         end
         S_COUNT: begin
            if (sdcka_posedge) begin
               st_state_d = S_IDLE;
               st_cnt_d   = 4'd0;
               if (st_cnt_q == CNT_FRAME)      sf_d    = 1'b1;
               else if (st_cnt_q == CNT_CRC)   crc_d   = 1'b1;
               else if (st_cnt_q == CNT_OCC)   occ_d   = 1'b1;
               else if (st_cnt_q == CNT_RESET) rst_d   = 1'b1;
               else                            sferr_d = 1'b1;
            end else if (sdckb_negedge && st_cnt_q != 4'd15) begin
               st_cnt_d = st_cnt_q + 4'd1;
            end
         end
         default: st_state_d = S_IDLE;
      endcase
   end

   // End pattern: B falls with A high, count A falls, classify on B rise.
   always_comb begin
      en_state_d = en_state_q;
      en_cnt_d   = en_cnt_q;
      ef_d       = 1'b0;
      eferr_d    = 1'b0;
      case (en_state_q)
         S_IDLE: begin
            if (sdckb_negedge && sdcka_data) begin
               en_state_d = S_COUNT;
               en_cnt_d   = 4'd0;
            end
         end
         S_COUNT: begin
            if (sdckb_posedge) begin
               en_state_d = S_IDLE;
               en_cnt_d   = 4'd0;
               if (en_cnt_q == CNT_END)    ef_d    = 1'b1;
               else if (en_cnt_q != 4'd0)  eferr_d = 1'b1;
            end else if (sdcka_negedge && en_cnt_q != 4'd15) begin
               en_cnt_d = en_cnt_q + 4'd1;
            end
         end
         default: en_state_d = S_IDLE;
      endcase
   end

   // Data bits alternate lines: phase A (0) samples B on A fall, phase B samples A on B fall.
   always_comb begin
      phase_d   = phase_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      data_d    = data_q;
      write_d   = 1'b0;
      take_bit  = 1'b0;
      bit_in    = 1'b0;
      if (!enable) begin
         phase_d   = 1'b0;
         bit_cnt_d = 3'd0;
      end else begin
         if (!phase_q && sdcka_negedge) begin
            take_bit = 1'b1;
            bit_in   = sdckb_data;
         end else if (phase_q && sdckb_negedge) begin
            take_bit = 1'b1;
            bit_in   = sdcka_data;
         end
         if (take_bit) begin
            phase_d = ~phase_q;
            if (bit_cnt_q == 3'd7) begin
               data_d    = {shift_q, bit_in};
               write_d   = 1'b1;
               bit_cnt_d = 3'd0;
            end else begin
               shift_d   = {shift_q[5:0], bit_in};
               bit_cnt_d = bit_cnt_q + 3'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st_state_q <= S_IDLE;
         st_cnt_q   <= 4'd0;
         en_state_q <= S_IDLE;
         en_cnt_q   <= 4'd0;
         sf_q       <= 1'b0;
         crc_q      <= 1'b0;
         occ_q      <= 1'b0;
         rst_q      <= 1'b0;
         sferr_q    <= 1'b0;
         ef_q       <= 1'b0;
         eferr_q    <= 1'b0;
         phase_q    <= 1'b0;
         bit_cnt_q  <= 3'd0;
         shift_q    <= 7'd0;
         data_q     <= 8'd0;
         write_q    <= 1'b0;
      end else begin
         st_state_q <= st_state_d;
         st_cnt_q   <= st_cnt_d;
         en_state_q <= en_state_d;
         en_cnt_q   <= en_cnt_d;
         sf_q       <= sf_d;
         crc_q      <= crc_d;
         occ_q      <= occ_d;
         rst_q      <= rst_d;
         sferr_q    <= sferr_d;
         ef_q       <= ef_d;
         eferr_q    <= eferr_d;
         phase_q    <= phase_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         write_q    <= write_d;
      end
   end

   assign start_frame       = sf_q;
   assign start_with_crc    = crc_q;
   assign start_occupancy   = occ_q;
   assign start_reset       = rst_q;
   assign start_frame_error = sferr_q;
   assign end_frame         = ef_q;
   assign end_frame_error   = eferr_q;
   assign data              = data_q;
   assign write             = write_q;

endmodule

// File: tb/tb_maple_frame_decoder.sv
// tb/tb_maple_frame_decoder.sv - directed and randomized checks of maple_frame_decoder
// Pulse vector order: start_frame, crc, occupancy, reset, start_err, end_frame, end_err, write.
module tb_maple_frame_decoder;

   logic       clk = 1'b0;
   logic       reset, enable;
   logic       sdcka_data, sdckb_data;
   logic       sdcka_posedge, sdcka_negedge, sdckb_posedge, sdckb_negedge;
   logic       start_frame, start_with_crc, start_occupancy, start_reset, start_frame_error;
   logic       end_frame, end_frame_error;
   logic [7:0] data;
   logic       write;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] seen;
   logic       ph;
   logic [7:0] pv;

   assign pv = {start_frame, start_with_crc, start_occupancy, start_reset,
                start_frame_error, end_frame, end_frame_error, write};

   maple_frame_decoder dut (
      .clk(clk), .reset(reset), .enable(enable),
      .sdcka_data(sdcka_data), .sdckb_data(sdckb_data),
      .sdcka_posedge(sdcka_posedge), .sdcka_negedge(sdcka_negedge),
      .sdckb_posedge(sdckb_posedge), .sdckb_negedge(sdckb_negedge),
      .start_frame(start_frame), .start_with_crc(start_with_crc),
      .start_occupancy(start_occupancy), .start_reset(start_reset),
      .start_frame_error(start_frame_error),
      .end_frame(end_frame), .end_frame_error(end_frame_error),
      .data(data), .write(write)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic ane, input logic ape, input logic bne, input logic bpe);
      sdcka_negedge = ane;
      sdcka_posedge = ape;
      sdckb_negedge = bne;
      sdckb_posedge = bpe;
      @(posedge clk);
      #1;
      sdcka_negedge = 1'b0;
      sdcka_posedge = 1'b0;
      sdckb_negedge = 1'b0;
      sdckb_posedge = 1'b0;
      seen = seen | pv;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc(0, 0, 0, 0);
      reset = 1'b0;
      ph = 1'b0;
   endtask

   function automatic logic [7:0] start_exp(input int n);
      int c;
      c = (n > 15) ? 15 : n;
      case (c)
         4:       return 8'h80;
         6:       return 8'h40;
         8:       return 8'h20;
         14:      return 8'h10;
         default: return 8'h08;
      endcase
   endfunction

   function automatic logic [7:0] end_exp(input int n);
      if (n == 2) return 8'h04;
      if (n == 0) return 8'h00;
      return 8'h02;
   endfunction

   task automatic start_pattern(input int n, input logic [7:0] exp, input string tag);
      seen = 8'h00;
      sdcka_data = 1'b0;
      sdckb_data = 1'b1;
      cyc(1, 0, 0, 0);
      for (int i = 0; i < n; i++) begin
         sdckb_data = 1'b0;
         cyc(0, 0, 1, 0);
         sdckb_data = 1'b1;
         cyc(0, 0, 0, 1);
      end
      chk({tag, "_quiet"}, 32'(seen), 32'h0);
      sdcka_data = 1'b1;
      cyc(0, 1, 0, 0);
      chk({tag, "_result"}, 32'(pv), 32'(exp));
      cyc(0, 0, 0, 0);
      chk({tag, "_after"}, 32'(pv), 32'h0);
   endtask

   task automatic end_pattern(input int n, input logic [7:0] exp, input string tag);
      seen = 8'h00;
      sdcka_data = 1'b1;
      sdckb_data = 1'b0;
      cyc(0, 0, 1, 0);
      for (int i = 0; i < n; i++) begin
         sdcka_data = 1'b0;
         cyc(1, 0, 0, 0);
         sdcka_data = 1'b1;
         cyc(0, 1, 0, 0);
      end
      chk({tag, "_quiet"}, 32'(seen), 32'h0);
      sdckb_data = 1'b1;
      cyc(0, 0, 0, 1);
      chk({tag, "_result"}, 32'(pv), 32'(exp));
      cyc(0, 0, 0, 0);
      chk({tag, "_after"}, 32'(pv), 32'h0);
   endtask

   // One data bit on whichever line the model's phase expects, optionally after a stray edge.
   task automatic send_bit(input logic b, input logic stray);
      if (stray) begin
         sdcka_data = 1'($urandom_range(0, 1));
         if (!ph) cyc(0, 0, 1, 0);
         else     cyc(1, 0, 0, 0);
      end
      if (!ph) begin
         sdckb_data = b;
         cyc(1, 0, 0, 0);
      end else begin
         sdcka_data = b;
         cyc(0, 0, 1, 0);
      end
      ph = ~ph;
   endtask

   task automatic send_byte(input logic [7:0] val, input logic strays, input string tag);
      logic [7:0] v;
      v = val;
      seen = 8'h00;
      for (int i = 7; i > 0; i--) send_bit(v[i], strays && ($urandom_range(0, 3) == 0));
      chk({tag, "_nowrite_early"}, 32'(seen), 32'h0);
      send_bit(v[0], 1'b0);
      chk({tag, "_write"}, 32'(pv), 32'h01);
      chk({tag, "_data"}, 32'(data), 32'(val));
      cyc(0, 0, 0, 0);
      chk({tag, "_hold"}, {23'h0, write, data}, {24'h0, val});
   endtask

   initial begin
      logic [7:0] rb;
      int         n;
      reset = 1'b0; enable = 1'b0;
      sdcka_data = 1'b1; sdckb_data = 1'b1;
      sdcka_posedge = 1'b0; sdcka_negedge = 1'b0;
      sdckb_posedge = 1'b0; sdckb_negedge = 1'b0;
      seen = 8'h00; ph = 1'b0;

      do_reset();
      chk("reset_pulses", 32'(pv), 32'h0);
      chk("reset_data", 32'(data), 32'h0);

      start_pattern(4, 8'h80, "start4");
      start_pattern(14, 8'h10, "start14");
      start_pattern(5, 8'h08, "start5");
      start_pattern(6, 8'h40, "start6");
      start_pattern(8, 8'h20, "start8");
      start_pattern(0, 8'h08, "start0");
      start_pattern(17, 8'h08, "start_sat");

      // A falling with B low must not arm the start decoder.
      seen = 8'h00;
      sdckb_data = 1'b0; sdcka_data = 1'b0;
      cyc(1, 0, 0, 0);
      sdcka_data = 1'b1; sdckb_data = 1'b1;
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 0);
      chk("start_noarm", 32'(seen), 32'h0);

      end_pattern(2, 8'h04, "end2");
      end_pattern(3, 8'h02, "end3");
      end_pattern(0, 8'h00, "end0");

      // Reset in the middle of a start pattern abandons it.
      seen = 8'h00;
      sdcka_data = 1'b0; sdckb_data = 1'b1;
      cyc(1, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         sdckb_data = 1'b0; cyc(0, 0, 1, 0);
         sdckb_data = 1'b1; cyc(0, 0, 0, 1);
      end
      do_reset();
      sdcka_data = 1'b1;
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 0);
      chk("reset_mid_start", 32'(seen), 32'h0);

      for (int k = 0; k < 12; k++) begin
         n = int'($urandom_range(0, 16));
         start_pattern(n, start_exp(n), $sformatf("rnd_start%0d_n%0d", k, n));
         n = int'($urandom_range(0, 5));
         end_pattern(n, end_exp(n), $sformatf("rnd_end%0d_n%0d", k, n));
      end

      // Data edges with enable low produce nothing.
      do_reset();
      seen = 8'h00;
      for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
      chk("disabled_nowrite", 32'(seen), 32'h0);
      chk("disabled_data", 32'(data), 32'h0);

      do_reset();
      enable = 1'b1;
      send_byte(8'hA5, 1'b0, "byteA5");
      send_byte(8'h3C, 1'b0, "byte3C");

      // Partial byte dropped when enable falls.
      seen = 8'h00;
      for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
      enable = 1'b0;
      cyc(0, 0, 0, 0);
      ph = 1'b0;
      enable = 1'b1;
      chk("partial_nowrite", 32'(seen), 32'h0);
      send_byte(8'h96, 1'b0, "fresh96");

      // Reset mid-byte clears data and restarts the byte.
      for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
      do_reset();
      chk("reset_mid_byte_data", 32'(data), 32'h0);
      send_byte(8'h5A, 1'b0, "after_reset5A");

      for (int k = 0; k < 10; k++) begin
         rb = 8'($urandom);
         send_byte(rb, 1'b1, $sformatf("rnd_byte%0d", k));
      end
      enable = 1'b0;
      cyc(0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/maple_frame_decoder.md
MAPLE_FRAME_DECODER -- requirements
Module: maple_frame_decoder

Interface
REQ-001 Parameter START_FRAME_PULSES, default 4: SDCKB falling-edge count that marks a normal start pattern.
REQ-002 Parameter START_CRC_PULSES, default 6: count that marks a start-with-CRC pattern.
REQ-003 Parameter START_OCC_PULSES, default 8: count that marks an occupancy start pattern.
REQ-004 Parameter START_RESET_PULSES, default 14: count that marks a bus-reset start pattern.
REQ-005 Parameter END_PULSES, default 2: SDCKA falling-edge count that marks an end pattern.
REQ-006 clk  in  1  single system clock; all logic on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 enable  in  1  high while a frame is open; gates the data decoder.
REQ-009 sdcka_data, sdckb_data  in  1 each  synchronized line levels.
REQ-010 sdcka_posedge, sdcka_negedge, sdckb_posedge, sdckb_negedge  in  1 each  one-cycle edge strobes for the matching synchronized line.
REQ-011 start_frame, start_with_crc, start_occupancy, start_reset, start_frame_error  out  1 each  one-cycle start-pattern result pulses.
REQ-012 end_frame, end_frame_error  out  1 each  one-cycle end-pattern result pulses.
REQ-013 data  out  8  last fully received byte.
REQ-014 write  out  1  one-cycle pulse when data has just been updated.

Function
REQ-015 All outputs SHALL be registered and SHALL assert in the cycle after the qualifying edge strobe is sampled.
REQ-016 Start decoder states: IDLE, COUNT.
- IDLE->COUNT on sdcka_negedge with sdckb_data=1; pulse counter cleared.
- sdcka_negedge with sdckb_data=0 SHALL NOT arm the decoder.
REQ-017 In COUNT, each sdckb_negedge SHALL increment a 4-bit counter that saturates at 15.
REQ-018 In COUNT, sdcka_posedge SHALL classify the count and return to IDLE:
- 4 -> start_frame
- 6 -> start_with_crc
- 8 -> start_occupancy
- 14 -> start_reset
- any other value, including 0 -> start_frame_error
REQ-019 At most one start output SHALL be high in any cycle.
REQ-020 End decoder states: IDLE, COUNT.
- IDLE->COUNT on sdckb_negedge with sdcka_data=1; counter cleared.
- In COUNT, each sdcka_negedge SHALL increment a saturating 4-bit counter.
REQ-021 In COUNT, sdckb_posedge SHALL classify the count and return to IDLE:
- count = END_PULSES -> end_frame
- count = 0 -> no output (normal data activity)
- any other value -> end_frame_error
REQ-022 Data decoder with enable=0: bit counter SHALL hold at 0, expected phase SHALL be A, and write SHALL stay 0.
REQ-023 Data decoder with enable=1:
- Phase A: sdcka_negedge samples sdckb_data as the next bit.
- Phase B: sdckb_negedge samples sdcka_data as the next bit.
- Phase toggles after every sampled bit.
- A falling edge on the non-expected line SHALL be ignored.
REQ-024 Bits SHALL be shifted in MSB first.
- On the 8th bit, data SHALL load the assembled byte, write SHALL pulse for one cycle, and the bit counter SHALL wrap to 0 while the phase continues alternating.
REQ-025 data SHALL hold its value between writes.
- A partial byte SHALL be discarded when enable falls.
REQ-026 All three decoders SHALL run concurrently and independently; no output of one SHALL gate another.
REQ-027 If strobes arrive in the same cycle, each decoder SHALL process its own transitions in that cycle.

Reset
REQ-028 While reset=1, both pattern decoders SHALL enter IDLE with counters at 0.
REQ-029 While reset=1, the data decoder SHALL clear its bit counter, phase and data to 0.
REQ-030 While reset=1, all pulse outputs SHALL be 0.
REQ-031 Reset asserted mid-pattern or mid-byte SHALL abandon that pattern or byte; no result pulse SHALL follow.

Verification
REQ-032 A falls with B high, 4 B pulses, A rises -> start_frame high exactly one cycle after the A rise strobe; no other start output.
REQ-033 Same sequence with 14 B pulses -> start_reset; with 5 B pulses -> start_frame_error.
REQ-034 enable=1, 8 alternating A/B falling edges carrying bits 1,0,1,0,0,1,0,1 -> data=0xA5 with a single write pulse; a second byte 0x3C -> data=0x3C with a second write pulse.
REQ-035 B falls with A high, 2 A pulses, B rises -> end_frame one cycle pulse; with 3 A pulses -> end_frame_error; with 0 A pulses -> no output.
REQ-036 reset=1 for one cycle after the 3rd B pulse of a start pattern, then A rises -> no start output.
REQ-037 enable dropped after 4 data bits, then raised and 8 fresh bits sent -> only the fresh byte is written.
